// File: rtl/pseq_pkg.sv
// Shared types for the programmable pattern-chain sequencer.
// FSM states and the default pattern type.
package pseq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HUNT = 1'b1
    } pseq_state_t;

    localparam int PSEQ_PAT_W = 5;

    typedef logic [PSEQ_PAT_W-1:0] pat_t;

endpackage

// File: rtl/pat_shift_match.sv
// Serial shift register with fill tracking and pattern compare.
// match is asserted once PAT_W fresh bits equal pat.
module pat_shift_match #(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    input  logic [PAT_W-1:0] pat,
    output logic             match
);

    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] shreg;
    logic [FW-1:0]    fill;

    // Shift newest bit into the LSB; fill saturates at PAT_W.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            shreg <= '0;
            fill  <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[PAT_W-2:0], din};
            if (fill != FW'(PAT_W))
                fill <= fill + FW'(1);
        end
    end

    assign match = (fill == FW'(PAT_W)) && (shreg == pat);

endmodule

// File: rtl/prog_seq_chain_ctrl.sv
// Pattern-chain sequencer: hunts table[0..len-1] in order on din.
// Reports per-stage hits, completion, or stage timeout.
module prog_seq_chain_ctrl
    import pseq_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int DEPTH = 4,
    parameter int TMO_W = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LW-1:0]    len,
    input  logic [TMO_W-1:0] tmo,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    output logic             busy,
    output logic [AW-1:0]    stage,
    output logic             hit,
    output logic             done,
    output logic             fail
);

    pseq_state_t state, state_n;

    logic [PAT_W-1:0] tbl [DEPTH];
    logic [AW-1:0]    stage_n;
    logic [LW-1:0]    len_r, len_n, len_cl;
    logic [TMO_W-1:0] tmo_r, tmo_n;
    logic [TMO_W-1:0] tcnt, tcnt_n;
    logic             hit_n, done_n, fail_n;
    logic             clr, shift_en, match;
    logic             last, tmo_hit;

    pat_shift_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (clr),
        .shift_en (shift_en),
        .din      (din),
        .pat      (tbl[stage]),
        .match    (match)
    );

    assign len_cl  = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign last    = (LW'(stage) + LW'(1)) == len_r;
    assign tmo_hit = (tmo_r != '0) && (tcnt == tmo_r - TMO_W'(1));

    // Pattern table: writable only while idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= '0;
        end else if (cfg_we && state == IDLE && int'(cfg_addr) < DEPTH) begin
            tbl[cfg_addr] <= cfg_pat;
        end
    end

    // State, counters and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            stage <= '0;
            len_r <= '0;
            tmo_r <= '0;
            tcnt  <= '0;
            hit   <= 1'b0;
            done  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            state <= state_n;
            stage <= stage_n;
            len_r <= len_n;
            tmo_r <= tmo_n;
            tcnt  <= tcnt_n;
            hit   <= hit_n;
            done  <= done_n;
            fail  <= fail_n;
        end
    end

    // Next state: abort beats match, match beats timeout.
    always_comb begin
        state_n  = state;
        stage_n  = stage;
        len_n    = len_r;
        tmo_n    = tmo_r;
        tcnt_n   = tcnt;
        hit_n    = 1'b0;
        done_n   = 1'b0;
        fail_n   = 1'b0;
        clr      = 1'b0;
        shift_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len_cl == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = HUNT;
                        len_n   = len_cl;
                        tmo_n   = tmo;
                        stage_n = '0;
                        tcnt_n  = '0;
                        clr     = 1'b1;
                    end
                end
            end
            HUNT: begin
                if (abort) begin
                    state_n = IDLE;
                    stage_n = '0;
                    tcnt_n  = '0;
                end else if (match) begin
                    clr    = 1'b1;
                    tcnt_n = '0;
                    hit_n  = 1'b1;
                    if (last) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                        stage_n = '0;
                    end else begin
                        stage_n = stage + AW'(1);
                    end
                end else if (tmo_hit) begin
                    fail_n  = 1'b1;
                    state_n = IDLE;
                    stage_n = '0;
                    tcnt_n  = '0;
                end else begin
                    shift_en = 1'b1;
                    tcnt_n   = tcnt + TMO_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == HUNT);

endmodule

// File: tb/tb_prog_seq_chain_ctrl.sv
// Randomised bench for prog_seq_chain_ctrl with an event-level model.
// Model finds each stage's first matching window in the bit stream.
module tb_prog_seq_chain_ctrl;
    import pseq_pkg::*;

    localparam int PAT_W = 5;
    localparam int DEPTH = 4;
    localparam int TMO_W = 8;

    logic       clk = 1'b0;
    logic       resetn, cfg_we, start, abort, din;
    logic [1:0] cfg_addr;
    pat_t       cfg_pat;
    logic [2:0] len;
    logic [7:0] tmo;
    logic       busy, hit, done, fail;
    logic [1:0] stage;

    int n_cmp = 0;
    int n_bad = 0;

    pat_t       tbl [DEPTH];
    bit         bits [256];
    int         cur_n;
    bit         e_hit [258];
    bit         e_done [258];
    bit         e_fail [258];
    int         e_stage [258];
    int         e_fin;
    logic [5:0] obs [258];
    logic [5:0] obs_cl;

    prog_seq_chain_ctrl #(
        .PAT_W (PAT_W),
        .DEPTH (DEPTH),
        .TMO_W (TMO_W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_pat  (cfg_pat),
        .len      (len),
        .tmo      (tmo),
        .start    (start),
        .abort    (abort),
        .din      (din),
        .busy     (busy),
        .stage    (stage),
        .hit      (hit),
        .done     (done),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] cur_obs();
        return {busy, stage, hit, done, fail};
    endfunction

    function automatic bit din_at(int h);
        return (h >= 1 && h <= cur_n) ? bits[h-1] : 1'b0;
    endfunction

    // Window of PAT_W bits ending the cycle before c, oldest bit = MSB.
    function automatic bit window_eq(int c, pat_t p);
        for (int j = 0; j < PAT_W; j++)
            if (din_at(c - PAT_W + j) != p[PAT_W-1-j])
                return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [5:0] exp_vec(int k);
        logic b;
        b = (e_fin < 0) ? 1'b1 : (k < e_fin);
        return {b, 2'(e_stage[k]), e_hit[k], e_done[k], e_fail[k]};
    endfunction

    // Cycle h carries bits[h-1]; a stage entered at cycle t can match
    // at cycle m >= t+PAT_W, must do so by t+tmo-1, and an abort at
    // cycle a suppresses everything from a onward.
    task automatic build_model(input int n, input int lenv,
                               input int tmov, input int abort_at);
        int  le, t, st, lim, m;
        bit  found, stop;
        le = (lenv > DEPTH) ? DEPTH : lenv;
        t = 1;
        st = 0;
        m = 0;
        stop = 1'b0;
        e_fin = -1;
        for (int k = 0; k < 258; k++) begin
            e_hit[k] = 1'b0;
            e_done[k] = 1'b0;
            e_fail[k] = 1'b0;
            e_stage[k] = 0;
        end
        if (le == 0) begin
            e_done[0] = 1'b1;
            e_fin = 0;
        end
        while (e_fin < 0 && st < le && !stop) begin
            lim = n;
            if (tmov != 0 && t + tmov - 1 < lim)
                lim = t + tmov - 1;
            if (abort_at > 0 && abort_at - 1 < lim)
                lim = abort_at - 1;
            found = 1'b0;
            for (int c = t + PAT_W; c <= lim; c++)
                if (!found && window_eq(c, tbl[st])) begin
                    found = 1'b1;
                    m = c;
                end
            if (found) begin
                e_hit[m] = 1'b1;
                for (int k = m; k < 258; k++)
                    e_stage[k] = st + 1;
                if (st == le - 1) begin
                    e_done[m] = 1'b1;
                    e_fin = m;
                end else begin
                    st++;
                    t = m + 1;
                end
            end else begin
                if (tmov != 0 && t + tmov - 1 <= n &&
                    (abort_at == 0 || t + tmov - 1 < abort_at)) begin
                    e_fail[t + tmov - 1] = 1'b1;
                    e_fin = t + tmov - 1;
                end
                stop = 1'b1;
            end
        end
        if (e_fin < 0 && abort_at > 0 && abort_at <= n)
            e_fin = abort_at;
        if (e_fin >= 0)
            for (int k = e_fin; k < 258; k++)
                e_stage[k] = 0;
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_pat = '0;
        start = 1'b0;
        abort = 1'b0;
        din = 1'b0;
        len = '0;
        tmo = '0;
    endtask

    task automatic write_cfg(input int a, input pat_t p);
        cfg_we = 1'b1;
        cfg_addr = 2'(a);
        cfg_pat = p;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        tbl[a] = p;
    endtask

    // Drives one hunt and records outputs after every edge.
    task automatic run_hunt(input int n, input int lenv, input int tmov,
                            input int abort_at, input bit noise,
                            input bit cleanup);
        cur_n = n;
        build_model(n, lenv, tmov, abort_at);
        idle_inputs();
        start = 1'b1;
        len = 3'(lenv);
        tmo = 8'(tmov);
        @(posedge clk);
        #1;
        obs[0] = cur_obs();
        for (int h = 1; h <= n; h++) begin
            start = 1'b0;
            din = bits[h-1];
            abort = (h == abort_at);
            if (noise && (e_fin < 0 || h <= e_fin)) begin
                cfg_we = 1'b1;
                cfg_addr = 2'd0;
                cfg_pat = 5'b11111;
                start = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk);
            #1;
            obs[h] = cur_obs();
        end
        idle_inputs();
        obs_cl = '0;
        if (e_fin < 0 && cleanup) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            obs_cl = cur_obs();
        end
    endtask

    task automatic load_bits(input int base, input pat_t p);
        for (int j = 0; j < PAT_W; j++)
            bits[base + j] = p[PAT_W-1-j];
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (cur_obs() !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_state cyc%0d got=%b want=%b",
                         i, cur_obs(), 6'b0);
            end
        end
        resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            tbl[i] = '0;
    endtask

    task automatic test_chain();
        write_cfg(0, 5'b10110);
        write_cfg(1, 5'b00111);
        load_bits(0, 5'b10110);
        bits[5] = 1'b0;
        load_bits(6, 5'b00111);
        for (int i = 11; i < 14; i++)
            bits[i] = 1'b0;
        run_hunt(14, 2, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k <= 14; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL chain k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
        n_cmp++;
        if (obs[6] !== 6'b1_01_100) begin
            n_bad++;
            $display("FAIL chain_hit0 got=%b want=%b", obs[6], 6'b101100);
        end
        n_cmp++;
        if (obs[12] !== 6'b0_00_110) begin
            n_bad++;
            $display("FAIL chain_done got=%b want=%b", obs[12], 6'b000110);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 12; i++)
            bits[i] = 1'b0;
        run_hunt(12, 1, 8, 0, 1'b0, 1'b1);
        for (int k = 0; k <= 12; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL timeout k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
        n_cmp++;
        if (obs[8] !== 6'b0_00_001 || obs[7] !== 6'b1_00_000) begin
            n_bad++;
            $display("FAIL timeout_edge got=%b,%b want=%b,%b",
                     obs[7], obs[8], 6'b100000, 6'b000001);
        end
    endtask

    task automatic test_cfg_locked();
        int s [13] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        for (int i = 0; i < 13; i++)
            bits[i] = s[i][0];
        run_hunt(13, 1, 0, 0, 1'b1, 1'b1);
        for (int k = 0; k <= 13; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL cfg_locked k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
        load_bits(0, tbl[0]);
        bits[5] = 1'b0;
        run_hunt(6, 1, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k <= 6; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL cfg_reread k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_len_zero();
        bits[0] = 1'b0;
        bits[1] = 1'b0;
        run_hunt(2, 0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k <= 2; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL len_zero k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_abort();
        load_bits(0, tbl[0]);
        for (int i = 5; i < 10; i++)
            bits[i] = 1'b0;
        run_hunt(10, 2, 0, 6, 1'b0, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL abort k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
        n_cmp++;
        if (obs[6] !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_match got=%b want=%b", obs[6], 6'b0);
        end
    endtask

    task automatic test_overlap_reset();
        int s [6] = '{1, 0, 1, 0, 1, 1};
        write_cfg(0, 5'b10101);
        write_cfg(1, 5'b01011);
        for (int i = 0; i < 6; i++)
            bits[i] = s[i][0];
        for (int i = 6; i < 10; i++)
            bits[i] = 1'b0;
        run_hunt(10, 2, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL overlap k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            tbl[i] = '0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cur_obs() !== 6'b0) begin
                n_bad++;
                $display("FAIL midhunt_reset cyc%0d got=%b want=%b",
                         i, cur_obs(), 6'b0);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++)
            bits[i] = 1'b0;
        run_hunt(8, 1, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k)) begin
                n_bad++;
                $display("FAIL table_cleared k=%0d got=%b want=%b",
                         k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        int n, lenv, tmov, ab, gap;
        bit noise;
        for (int it = 0; it < 40; it++) begin
            for (int a = 0; a < DEPTH; a++)
                if ($urandom_range(0, 1) == 1)
                    write_cfg(a, 5'($urandom));
            n = 0;
            for (int st = 0; st < DEPTH; st++) begin
                gap = $urandom_range(0, 4);
                for (int g = 0; g < gap; g++)
                    bits[n++] = 1'($urandom);
                load_bits(n, tbl[st]);
                n += PAT_W;
                bits[n++] = 1'($urandom);
            end
            for (int g = 0; g < 3; g++)
                bits[n++] = 1'($urandom);
            lenv = $urandom_range(0, 6);
            tmov = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(4, 30);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            noise = ($urandom_range(0, 3) == 0);
            run_hunt(n, lenv, tmov, ab, noise, 1'b1);
            for (int k = 0; k <= n; k++) begin
                n_cmp++;
                if (obs[k] !== exp_vec(k)) begin
                    n_bad++;
                    $display("FAIL random it%0d k=%0d got=%b want=%b",
                             it, k, obs[k], exp_vec(k));
                end
            end
            if (e_fin < 0) begin
                n_cmp++;
                if (obs_cl !== 6'b0) begin
                    n_bad++;
                    $display("FAIL random_abort it%0d got=%b want=%b",
                             it, obs_cl, 6'b0);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_chain();
        test_timeout();
        test_cfg_locked();
        test_len_zero();
        test_abort();
        test_overlap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
